// File: rtl/key_event_module.sv
// Key event classifier: turns a debounced key level into short-press,
// long-press and double-click pulses using a 1 ms timebase.
module key_event_module #(
    parameter logic [15:0] T1MS      = 16'd49_999,
    parameter logic [11:0] LONG_MS   = 12'd1000,
    parameter logic [11:0] DCLICK_MS = 12'd250
) (
    input  logic CLK,
    input  logic RST,
    input  logic Key_In,
    output logic Short_Pulse,
    output logic Long_Pulse,
    output logic Double_Pulse,
    output logic Busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRESS1    = 3'd1;
    localparam logic [2:0] LONG_HOLD = 3'd2;
    localparam logic [2:0] WAIT2     = 3'd3;
    localparam logic [2:0] PRESS2    = 3'd4;

    logic [2:0]  state;
    logic [2:0]  nxt;
    logic        prev;
    logic [15:0] presc;
    logic [11:0] ms_cnt;
    logic        rise;
    logic        fall;
    logic        set_short;
    logic        set_long;
    logic        set_double;
    logic        timing;

    assign rise   = Key_In & ~prev;
    assign fall   = ~Key_In & prev;
    assign timing = (state == PRESS1) || (state == WAIT2);

    // Next state and event selection; a key edge always wins over a timeout.
    always_comb begin
        nxt        = state;
        set_short  = 1'b0;
        set_long   = 1'b0;
        set_double = 1'b0;
        case (state)
            IDLE: begin
                if (rise) nxt = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    nxt = WAIT2;
                end else if (ms_cnt == LONG_MS) begin
                    nxt      = LONG_HOLD;
                    set_long = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (fall) nxt = IDLE;
            end
            WAIT2: begin
                if (rise) begin
                    nxt = PRESS2;
                end else if (ms_cnt == DCLICK_MS) begin
                    nxt       = IDLE;
                    set_short = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    nxt        = IDLE;
                    set_double = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // State, key history and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            prev         <= 1'b1;
            Short_Pulse  <= 1'b0;
            Long_Pulse   <= 1'b0;
            Double_Pulse <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            state        <= nxt;
            prev         <= Key_In;
            Short_Pulse  <= set_short;
            Long_Pulse   <= set_long;
            Double_Pulse <= set_double;
            Busy         <= (nxt != IDLE);
        end
    end

    // Millisecond timebase; restarts on every state change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc  <= 16'd0;
            ms_cnt <= 12'd0;
        end else if ((nxt != state) || !timing) begin
            presc  <= 16'd0;
            ms_cnt <= 12'd0;
        end else if (presc == T1MS) begin
            presc  <= 16'd0;
            ms_cnt <= ms_cnt + 12'd1;
        end else begin
            presc  <= presc + 16'd1;
        end
    end

endmodule
